backlight_scheduler: RTL and testbench

Shares the watch backlight between three on-chip requesters (debounced button, alarm, hourly chime), grants one source at a time by fixed priority, and holds the light on for a per-source duration counted in whole seconds. Sits between the UI/alarm logic and the backlight driver pin, replacing any per-source light timers. An optional fade-out phase PWM-dims the light before it turns off.

---
 rtl/backlight_pkg.sv | 34 +++
 rtl/sec_tick_gen.sv | 28 ++
 rtl/backlight_scheduler.sv | 163 ++++++++++++++++
 tb/tb_backlight_scheduler.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/backlight_pkg.sv
// Shared types for the backlight scheduler: FSM states, source codes and the
// source priority compare.
package backlight_pkg;

  localparam int SECS_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_FADE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_BTN   = 2'd1,
    SRC_ALARM = 2'd2,
    SRC_CHIME = 2'd3
  } src_e;

  // Grant priority: alarm > button > chime > none.
  function automatic logic [1:0] src_rank(input src_e s);
    case (s)
      SRC_ALARM: return 2'd3;
      SRC_BTN:   return 2'd2;
      SRC_CHIME: return 2'd1;
      default:   return 2'd0;
    endcase
  endfunction

  function automatic src_e higher_src(input src_e a, input src_e b);
    return (src_rank(b) > src_rank(a)) ? b : a;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 and pulses tick for one cycle on
// the last count; restart clears the count synchronously.
module sec_tick_gen #(
  parameter int TICK_DIV = 32768
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick = (cnt_q == CNT_LAST);
    if (restart || tick) cnt_d = '0;
    else                 cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/backlight_scheduler.sv
// Fixed-priority backlight arbiter with per-source hold time in seconds.
// Define BACKLIGHT_FADE_EN to add a PWM fade-out phase before the light turns off.
module backlight_scheduler
  import backlight_pkg::*;
#(
  parameter int TICK_DIV   = 32768,
  parameter int BTN_SECS   = 3,
  parameter int ALARM_SECS = 10,
  parameter int CHIME_SECS = 2,
  parameter int FADE_STEP  = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_backlight,
  input  logic              alarm_req,
  input  logic              chime_req,
  input  logic              inhibit,
  output logic              light,
  output logic [1:0]        active_src,
  output logic [SECS_W-1:0] secs_left
);

  if (TICK_DIV < 2 || TICK_DIV > 65536 || FADE_STEP < 1 ||
      BTN_SECS > 15 || ALARM_SECS > 15 || CHIME_SECS > 15 ||
      BTN_SECS < 0 || ALARM_SECS < 0 || CHIME_SECS < 0) begin : g_bad_param
    $error("backlight_scheduler: parameter out of range");
  end

  state_e             state_q, state_d;
  src_e               src_q, src_d, new_src;
  logic [SECS_W-1:0]  secs_q, secs_d, new_secs;
  logic [2:0]         req_q, req_d, rise;
  logic               armed_q, armed_d;
  logic               light_q, light_d;
  logic               acc_alarm, acc_btn, acc_chime, any_acc, blocked;
  logic               restart, tick;

`ifdef BACKLIGHT_FADE_EN
  localparam int FW = $clog2(FADE_STEP + 1);
  logic [3:0]    duty_q, duty_d, pwm_q, pwm_d;
  logic [FW-1:0] fade_cnt_q, fade_cnt_d;
`endif

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_sec_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    req_d   = {alarm_req, btn_backlight, chime_req};
    armed_d = 1'b1;
    // First cycle after reset only loads the edge registers, so a level held
    // through reset is never mistaken for a new request.
    rise    = armed_q ? (req_d & ~req_q) : 3'b000;

    acc_alarm = rise[2] && (ALARM_SECS != 0);
    acc_btn   = rise[1] && (BTN_SECS != 0) && !inhibit;
    acc_chime = rise[0] && (CHIME_SECS != 0) && !inhibit;
    any_acc   = acc_alarm || acc_btn || acc_chime;

    new_src  = SRC_NONE;
    new_secs = '0;
    if (acc_chime) begin new_src = SRC_CHIME; new_secs = SECS_W'(CHIME_SECS); end
    if (acc_btn)   begin new_src = SRC_BTN;   new_secs = SECS_W'(BTN_SECS);   end
    if (acc_alarm) begin new_src = SRC_ALARM; new_secs = SECS_W'(ALARM_SECS); end

    blocked = inhibit && (src_q == SRC_BTN || src_q == SRC_CHIME);

    state_d = state_q;
    src_d   = src_q;
    secs_d  = secs_q;
    restart = 1'b0;
`ifdef BACKLIGHT_FADE_EN
    duty_d     = duty_q;
    pwm_d      = pwm_q + 4'd1;
    fade_cnt_d = fade_cnt_q;
`endif

    // In IDLE src_q is NONE and secs_q is 0, so merge-with-current also
    // covers a fresh grant.
    if (any_acc) begin
      state_d = ST_ON;
      restart = 1'b1;
      src_d   = higher_src(src_q, new_src);
      secs_d  = (new_secs > secs_q) ? new_secs : secs_q;
    end else if (state_q != ST_IDLE && blocked) begin
      state_d = ST_IDLE;
      src_d   = SRC_NONE;
      secs_d  = '0;
    end else if (state_q == ST_ON && tick) begin
      if (secs_q > SECS_W'(1)) begin
        secs_d = secs_q - SECS_W'(1);
      end else begin
        secs_d = '0;
`ifdef BACKLIGHT_FADE_EN
        state_d    = ST_FADE;
        duty_d     = 4'd15;
        pwm_d      = 4'd0;
        fade_cnt_d = '0;
`else
        state_d = ST_IDLE;
        src_d   = SRC_NONE;
`endif
      end
    end
`ifdef BACKLIGHT_FADE_EN
    else if (state_q == ST_FADE) begin
      if (fade_cnt_q == FW'(FADE_STEP - 1)) begin
        fade_cnt_d = '0;
        duty_d     = duty_q - 4'd1;
        if (duty_q == 4'd1) begin
          state_d = ST_IDLE;
          src_d   = SRC_NONE;
        end
      end else begin
        fade_cnt_d = fade_cnt_q + FW'(1);
      end
    end
    light_d = (state_d == ST_ON) || (state_d == ST_FADE && pwm_d < duty_d);
`else
    light_d = (state_d == ST_ON);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      src_q   <= SRC_NONE;
      secs_q  <= '0;
      req_q   <= '0;
      armed_q <= 1'b0;
      light_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      secs_q  <= secs_d;
      req_q   <= req_d;
      armed_q <= armed_d;
      light_q <= light_d;
    end
  end

`ifdef BACKLIGHT_FADE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_q     <= '0;
      pwm_q      <= '0;
      fade_cnt_q <= '0;
    end else begin
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
      fade_cnt_q <= fade_cnt_d;
    end
  end
`endif

  assign light      = light_q;
  assign active_src = src_q;
  assign secs_left  = secs_q;

endmodule

// File: tb/tb_backlight_scheduler.sv
// Scoreboard bench for backlight_scheduler with TICK_DIV=8, FADE_STEP=4.
module tb_backlight_scheduler;

  localparam int TICK_DIV  = 8;
  localparam int FADE_STEP = 4;

  typedef struct {
    string      tag;
    logic       l;
    logic [1:0] s;
    logic [3:0] secs;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn = 1'b0, alarm = 1'b0, chime = 1'b0, inhibit = 1'b0;
  logic       light;
  logic [1:0] active_src;
  logic [3:0] secs_left;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  backlight_scheduler #(
    .TICK_DIV(TICK_DIV), .BTN_SECS(3), .ALARM_SECS(10), .CHIME_SECS(2),
    .FADE_STEP(FADE_STEP)
  ) dut (
    .clk(clk), .reset(reset), .btn_backlight(btn), .alarm_req(alarm),
    .chime_req(chime), .inhibit(inhibit), .light(light),
    .active_src(active_src), .secs_left(secs_left)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the expected outputs, advance n cycles, then pop and compare.
  task automatic expect_after(input int n, input string tag, input logic l,
                              input logic [1:0] s, input logic [3:0] secs);
    exp_t e;
    e.tag = tag; e.l = l; e.s = s; e.secs = secs;
    sb_q.push_back(e);
    repeat (n) step();
    e = sb_q.pop_front();
    check_val({e.tag, ".light"}, 32'(light), 32'(e.l));
    check_val({e.tag, ".src"}, 32'(active_src), 32'(e.s));
    check_val({e.tag, ".secs"}, 32'(secs_left), 32'(e.secs));
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    #1;
    expect_after(0, tag, 1'b0, 2'd0, 4'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef BACKLIGHT_FADE_EN
    int lit, exp_lit;
`endif
    #1;
    expect_after(0, "reset", 1'b0, 2'd0, 4'd0);
    step(); step();
    reset = 1'b1;
    step(); step();

    // Button pulse from IDLE, full expiry.
    btn = 1'b1; expect_after(1, "btn_grant", 1'b1, 2'd1, 4'd3);
    btn = 1'b0; expect_after(7, "btn_pre_tick", 1'b1, 2'd1, 4'd3);
    expect_after(1, "btn_tick1", 1'b1, 2'd1, 4'd2);
    expect_after(8, "btn_tick2", 1'b1, 2'd1, 4'd1);
    expect_after(7, "btn_last", 1'b1, 2'd1, 4'd1);
`ifdef BACKLIGHT_FADE_EN
    expect_after(1, "fade_entry", 1'b1, 2'd1, 4'd0);
    lit = int'(light);
    for (int i = 1; i < 60; i++) begin
      step();
      lit += int'(light);
    end
    exp_lit = 0;
    for (int i = 0; i < 60; i++)
      if ((i % 16) < (15 - i / 4)) exp_lit++;
    check_val("fade_duty_cycles", 32'(lit), 32'(exp_lit));
    expect_after(1, "fade_done", 1'b0, 2'd0, 4'd0);

    // Retrigger during fade, then reset while fading.
    btn = 1'b1; expect_after(1, "btn_grant_f", 1'b1, 2'd1, 4'd3);
    btn = 1'b0; expect_after(24, "fade_entry2", 1'b1, 2'd1, 4'd0);
    step(); step(); step(); step(); step(); step(); step(); step(); step(); step();
    btn = 1'b1; expect_after(1, "fade_retrig", 1'b1, 2'd1, 4'd3);
    btn = 1'b0; expect_after(24, "fade_entry3", 1'b1, 2'd1, 4'd0);
    step(); step(); step(); step(); step();
    pulse_reset("fade_reset");
`else
    expect_after(1, "btn_off", 1'b0, 2'd0, 4'd0);
`endif

    // Chime preempted by alarm, then button under alarm.
    step(); step();
    chime = 1'b1; expect_after(1, "chime_grant", 1'b1, 2'd3, 4'd2);
    chime = 1'b0;
    step(); step(); step();
    alarm = 1'b1; expect_after(1, "alarm_preempt", 1'b1, 2'd2, 4'd10);
    alarm = 1'b0; expect_after(7, "alarm_restart_hold", 1'b1, 2'd2, 4'd10);
    expect_after(1, "alarm_tick", 1'b1, 2'd2, 4'd9);
    step(); step(); step();
    btn = 1'b1; expect_after(1, "btn_in_alarm", 1'b1, 2'd2, 4'd9);
    expect_after(7, "btn_in_alarm_restart", 1'b1, 2'd2, 4'd9);
    expect_after(1, "btn_in_alarm_tick", 1'b1, 2'd2, 4'd8);

    // Reset mid-grant with button still held.
    pulse_reset("async_reset");
    expect_after(10, "held_req_ignored", 1'b0, 2'd0, 4'd0);
    btn = 1'b0;

    // Inhibit cases.
    inhibit = 1'b1; step();
    btn = 1'b1; expect_after(1, "inh_btn_blocked", 1'b0, 2'd0, 4'd0);
    expect_after(3, "inh_btn_stays_off", 1'b0, 2'd0, 4'd0);
    btn = 1'b0; inhibit = 1'b0; step();
    btn = 1'b1; expect_after(1, "btn_grant2", 1'b1, 2'd1, 4'd3);
    btn = 1'b0; step(); step();
    inhibit = 1'b1; expect_after(1, "inh_drop_btn", 1'b0, 2'd0, 4'd0);
    inhibit = 1'b0; step();
    alarm = 1'b1; expect_after(1, "alarm_grant", 1'b1, 2'd2, 4'd10);
    alarm = 1'b0; inhibit = 1'b1;
    expect_after(3, "inh_alarm_kept", 1'b1, 2'd2, 4'd10);
    inhibit = 1'b0;
    pulse_reset("reset2");

    // Request edge on the cycle of the final tick.
    chime = 1'b1; expect_after(1, "chime_grant2", 1'b1, 2'd3, 4'd2);
    chime = 1'b0; expect_after(8, "chime_tick", 1'b1, 2'd3, 4'd1);
    expect_after(7, "chime_last", 1'b1, 2'd3, 4'd1);
    btn = 1'b1; expect_after(1, "req_on_last_tick", 1'b1, 2'd1, 4'd3);
    btn = 1'b0; expect_after(7, "collide_restart", 1'b1, 2'd1, 4'd3);
    expect_after(1, "collide_tick", 1'b1, 2'd1, 4'd2);
    pulse_reset("reset3");

    // Simultaneous button and chime from IDLE: button wins.
    btn = 1'b1; chime = 1'b1;
    expect_after(1, "simul_btn_chime", 1'b1, 2'd1, 4'd3);
    btn = 1'b0; chime = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
